lstm_layer_tm: RTL and testbench
================================

# lstm_layer_tm

Time-multiplexed, parametrised LSTM layer of UNITS hidden cells, built around one shared multiply-accumulate unit. It consumes a scalar input stream over a valid/ready handshake and keeps recurrent h/c state across time steps. After each step it emits the full h and c vectors over a valid/ready handshake. It generalises the single-cell lstm to N units with full recurrent matrices, sequence boundaries, back-pressure and saturating fixed-point arithmetic.

## Interface
- WIDTH, 16: signed fixed-point word width.
- FRAC, 12: fractional bits. One = 1<<FRAC.
- UNITS, 4: number of hidden units, ≥1.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- weight_x  in  UNITS×4×WIDTH  input weight [u][g], g: 0=i, 1=f, 2=g, 3=o.
- weight_h  in  UNITS×4×UNITS×WIDTH  recurrent weight [u][g][k].
- bias  in  UNITS×4×WIDTH  gate bias [u][g].
- h_init, c_init  in  UNITS×WIDTH  state loaded at the start of each sequence.
- x_in  in  WIDTH  input sample.
- x_last  in  1  marks the final sample of a sequence.
- x_valid  in  1  / x_ready  out  1: input handshake.
- y_out  out  UNITS×WIDTH  new h vector.
- C_out  out  UNITS×WIDTH  new c vector.
- y_valid  out  1  / y_ready  in  1: output handshake.
- Weights, biases and init vectors are not latched. They must stay stable while a step is in progress.

## Operation
- FSM states: IDLE, MAC, ACT, UPD_C, UPD_H, OUT.
- IDLE: x_ready=1. On x_valid, register x_in and x_last, then go to MAC with u=0, g=0, k=0.
  - If seq_start=1, load h/c state from h_init/c_init and clear seq_start.
- MAC, per unit u and per gate g in order i, f, g, o:
  - First cycle: acc = bias + weight_x·x.
  - Then UNITS cycles: acc += weight_h[u][g][k]·h[k].
  - The gate result is stored narrowed.
  - After gate o, go to ACT.
- ACT: apply activations to all four gates of unit u.
  - i, f, o use hard sigmoid: clamp((z>>>2) + one/2, 0, one).
  - g uses hard tanh: clamp(z, −one, one).
- UPD_C: c_new[u] = f·c[u] + i·g.
- UPD_H: h_new[u] = o·clamp(c_new[u], −one, one).
  - Then move to the next u via MAC, or go to OUT after the last unit.
- MAC always reads the old h. h_new/c_new are held in shadow registers.
- OUT: y_valid=1, y_out=h_new, C_out=c_new, held stable until y_ready.
  - On the handshake, commit shadows to state, set seq_start=x_last, go to IDLE.
- Width rules:
  - Products are full 2·WIDTH.
  - The accumulator is 2·WIDTH + clog2(UNITS+2) bits.
  - Narrowing is an arithmetic shift right by FRAC, then saturation to the signed WIDTH range.
  - The f·c + i·g sum is formed at full width before narrowing.
- Reset: state → IDLE; seq_start=1; h, c and shadows = 0; y_valid=0, y_out=0, C_out=0, x_ready=0 during reset.
  - Reset mid-step discards the step with no partial output.

## Timing
- Handshake at edge T gives y_valid high from edge T+L.
  - L = UNITS·(4·UNITS+7)+1, so 93 for UNITS=4 and 12 for UNITS=1.
- x_ready=0 from T+1 until the cycle after the output handshake.
- Minimum period between accepted samples is L+1 cycles.
- The first x_ready=1 is the cycle after rst deasserts.
- y_valid never drops without y_ready.

## Structure
- lstm_pkg holds:
  - Gate index constants GATE_I/F/G/O.
  - The FSM state enum.
  - Functions sat_narrow, hard_sigmoid, hard_tanh, parametrised by WIDTH/FRAC.
- Sub-module lstm_mac: shared multiplier plus accumulator with clear/accumulate/narrow controls.
- The UPD_C/UPD_H multiplies may reuse the lstm_mac multiplier, or use dedicated multipliers, within the latency above.

## Test plan
- UNITS=1, FRAC=12, all weights/biases 0, c_init=4096, h_init=0:
  - Expect y_out=1024, C_out=2048.
  - y_valid rises exactly 12 cycles after the handshake.
- Saturation:
  - Set weight_x[0][i]=32767, x=32767 and bias_i=32767, with g/o biases 32767 and f bias −32768.
  - The gate accumulator saturates.
  - Expect C_out=4096, y_out=4096, and no wrap to negative values.
- Back-pressure: hold y_ready=0 for 20 cycles.
  - y_out/C_out stay stable and x_ready=0 throughout.
  - After the handshake, x_ready=1 on the next cycle.
- Sequence boundary: run 2 steps with x_last on the second, then a 3rd step with the same x as step 1.
  - Step 3 output must equal step 1 output, proving init values were reloaded.
- Reset mid-step: assert rst at cycle 40 of a UNITS=4 step.
  - y_valid stays 0 and x_ready returns to 1 the cycle after release.
  - The next step matches the golden model from h_init/c_init.
- UNITS=2 or 4 random weights, 50-sample sequence:
  - Bit-exact match against the golden model using the same shift/saturate rules.
  - Confirms recurrence uses old h for all units.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared definitions for the time-multiplexed LSTM layer: gate indices, FSM
// states and the fixed-point narrowing/activation helpers.
package lstm_pkg;

  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_G = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  typedef enum logic [2:0] {IDLE, MAC, ACT, UPD_C, UPD_H, OUT} state_t;

  // Arithmetic shift by frac, then saturate into the signed width range.
  function automatic longint sat_narrow(input longint v, input int width, input int frac);
    longint s, mx;
    s  = v >>> frac;
    mx = (longint'(1) <<< (width - 1)) - 1;
    if (s > mx) return mx;
    if (s < -mx - 1) return -mx - 1;
    return s;
  endfunction

  function automatic longint hard_sigmoid(input longint z, input int frac);
    longint one, s;
    one = longint'(1) <<< frac;
    s   = (z >>> 2) + (one >>> 1);
    if (s > one) return one;
    if (s < 0) return 0;
    return s;
  endfunction

  function automatic longint hard_tanh(input longint z, input int frac);
    longint one;
    one = longint'(1) <<< frac;
    if (z > one) return one;
    if (z < -one) return -one;
    return z;
  endfunction

endpackage

// File: rtl/lstm_mac.sv
// Shared multiply-accumulate: load starts a gate sum with bias plus one
// product, acc_en adds further products, nar is the narrowed running sum.
module lstm_mac import lstm_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int AW    = 35
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     bias,
  output logic signed [AW-1:0] acc,
  output logic [WIDTH-1:0]     nar
);

  logic signed [2*WIDTH-1:0] prod;

  assign prod = $signed(a) * $signed(b);
  assign nar  = WIDTH'(sat_narrow(longint'(acc), WIDTH, FRAC));

  // Bias is a Q(FRAC) word; products are Q(2*FRAC), so align the bias first.
  always_ff @(posedge clk) begin
    if (!rst)        acc <= '0;
    else if (load)   acc <= AW'(prod) + (AW'($signed(bias)) <<< FRAC);
    else if (acc_en) acc <= acc + AW'(prod);
  end

endmodule

// File: rtl/lstm_layer_tm.sv
// Time-multiplexed LSTM layer: UNITS cells share one MAC, recurrent h/c state
// persists across samples and reloads from h_init/c_init at sequence start.
module lstm_layer_tm import lstm_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int UNITS = 4
)(
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [UNITS-1:0][3:0][WIDTH-1:0]             weight_x,
  input  logic [UNITS-1:0][3:0][UNITS-1:0][WIDTH-1:0]  weight_h,
  input  logic [UNITS-1:0][3:0][WIDTH-1:0]             bias,
  input  logic [UNITS-1:0][WIDTH-1:0]                  h_init,
  input  logic [UNITS-1:0][WIDTH-1:0]                  c_init,
  input  logic [WIDTH-1:0]                             x_in,
  input  logic                                         x_last,
  input  logic                                         x_valid,
  output logic                                         x_ready,
  output logic [UNITS-1:0][WIDTH-1:0]                  y_out,
  output logic [UNITS-1:0][WIDTH-1:0]                  C_out,
  output logic                                         y_valid,
  input  logic                                         y_ready
);

  localparam int AW = 2*WIDTH + $clog2(UNITS+2);
  localparam int UW = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int KW = $clog2(UNITS+1);
  localparam logic [UW-1:0] ULAST = UW'(UNITS-1);
  localparam logic [KW-1:0] KLAST = KW'(UNITS);

  state_t state, nxt;
  logic [UW-1:0] u, kidx;
  logic [KW-1:0] k;
  logic [1:0]    g;
  logic [WIDTH-1:0] x_reg;
  logic xl_reg, seq_start;
  logic [UNITS-1:0][WIDTH-1:0] h_st, c_st, h_sh, c_sh;
  logic [2:0][WIDTH-1:0] zg;
  logic [WIDTH-1:0] a_i, a_f, a_g, a_o, c_upd, h_upd;

  logic mac_load, mac_acc;
  logic [WIDTH-1:0] ma, mb, mbias, mac_nar;
  logic signed [AW-1:0] mac_acc_q;

  lstm_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .AW(AW)) u_mac (
    .clk(clk), .rst(rst), .load(mac_load), .acc_en(mac_acc),
    .a(ma), .b(mb), .bias(mbias), .acc(mac_acc_q), .nar(mac_nar)
  );

  assign kidx    = UW'(k - KW'(1));
  assign x_ready = rst && (state == IDLE);

  // Cell update datapath; c_sh[u] is written in UPD_C and read back in UPD_H.
  assign c_upd = WIDTH'(sat_narrow(longint'($signed(a_f)) * longint'($signed(c_st[u]))
                                 + longint'($signed(a_i)) * longint'($signed(a_g)), WIDTH, FRAC));
  assign h_upd = WIDTH'(sat_narrow(longint'($signed(a_o))
                                 * hard_tanh(longint'($signed(c_sh[u])), FRAC), WIDTH, FRAC));

  always_comb begin
    nxt      = state;
    mac_load = 1'b0;
    mac_acc  = 1'b0;
    ma       = weight_x[u][g];
    mb       = x_reg;
    mbias    = bias[u][g];
    case (state)
      IDLE:  if (x_valid) nxt = MAC;
      MAC: begin
        if (k == '0) mac_load = 1'b1;
        else begin
          mac_acc = 1'b1;
          ma      = weight_h[u][g][kidx];
          mb      = h_st[kidx];
        end
        if (k == KLAST && g == GATE_O) nxt = ACT;
      end
      ACT:   nxt = UPD_C;
      UPD_C: nxt = UPD_H;
      UPD_H: nxt = (u == ULAST) ? OUT : MAC;
      OUT:   if (y_valid && y_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      seq_start <= 1'b1;
      u         <= '0;
      k         <= '0;
      g         <= '0;
      x_reg     <= '0;
      xl_reg    <= 1'b0;
      h_st      <= '0;
      c_st      <= '0;
      h_sh      <= '0;
      c_sh      <= '0;
      zg        <= '0;
      a_i       <= '0;
      a_f       <= '0;
      a_g       <= '0;
      a_o       <= '0;
      y_valid   <= 1'b0;
      y_out     <= '0;
      C_out     <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (x_valid) begin
          x_reg  <= x_in;
          xl_reg <= x_last;
          u      <= '0;
          k      <= '0;
          g      <= '0;
          if (seq_start) begin
            h_st      <= h_init;
            c_st      <= c_init;
            seq_start <= 1'b0;
          end
        end
        MAC: begin
          // The previous gate's sum is still in the accumulator on the load cycle.
          if (k == '0 && g != GATE_I) zg[g - 2'd1] <= mac_nar;
          if (k == KLAST) begin
            k <= '0;
            g <= g + 2'd1;
          end else k <= k + KW'(1);
        end
        ACT: begin
          a_i <= WIDTH'(hard_sigmoid(longint'($signed(zg[GATE_I])), FRAC));
          a_f <= WIDTH'(hard_sigmoid(longint'($signed(zg[GATE_F])), FRAC));
          a_g <= WIDTH'(hard_tanh(longint'($signed(zg[GATE_G])), FRAC));
          a_o <= WIDTH'(hard_sigmoid(longint'($signed(mac_nar)), FRAC));
        end
        UPD_C: c_sh[u] <= c_upd;
        UPD_H: begin
          h_sh[u] <= h_upd;
          if (u != ULAST) u <= u + UW'(1);
        end
        OUT: begin
          // Output registers load on the first OUT cycle and hold until accepted.
          if (!y_valid) begin
            y_valid <= 1'b1;
            y_out   <= h_sh;
            C_out   <= c_sh;
          end else if (y_ready) begin
            y_valid   <= 1'b0;
            h_st      <= h_sh;
            c_st      <= c_sh;
            seq_start <= xl_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_layer_tm.sv
// Directed bench for lstm_layer_tm: a UNITS=1 instance for hand-computed
// vectors and a UNITS=4 instance checked against a behavioural model.
module tb_lstm_layer_tm;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [0:0][3:0][W-1:0] wx1, b1;
  logic [0:0][3:0][0:0][W-1:0] wh1;
  logic [0:0][W-1:0] hi1, ci1, y1, c1o;
  logic [W-1:0] x1;
  logic xl1, xv1, xr1, yv1, yr1;

  logic [3:0][3:0][W-1:0] wx4, b4;
  logic [3:0][3:0][3:0][W-1:0] wh4;
  logic [3:0][W-1:0] hi4, ci4, y4, c4o;
  logic [W-1:0] x4;
  logic xl4, xv4, xr4, yv4, yr4;

  int checks = 0, failures = 0;
  longint mh[4], mc[4], eh[4], ec[4];

  lstm_layer_tm #(.WIDTH(16), .FRAC(12), .UNITS(1)) dut1 (
    .clk(clk), .rst(rst), .weight_x(wx1), .weight_h(wh1), .bias(b1),
    .h_init(hi1), .c_init(ci1), .x_in(x1), .x_last(xl1), .x_valid(xv1),
    .x_ready(xr1), .y_out(y1), .C_out(c1o), .y_valid(yv1), .y_ready(yr1));

  lstm_layer_tm #(.WIDTH(16), .FRAC(12), .UNITS(4)) dut4 (
    .clk(clk), .rst(rst), .weight_x(wx4), .weight_h(wh4), .bias(b4),
    .h_init(hi4), .c_init(ci4), .x_in(x4), .x_last(xl4), .x_valid(xv4),
    .x_ready(xr4), .y_out(y4), .C_out(c4o), .y_valid(yv4), .y_ready(yr4));

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_init();
    for (int u = 0; u < 4; u++) begin
      mh[u] = longint'($signed(hi4[u]));
      mc[u] = longint'($signed(ci4[u]));
    end
  endtask

  task automatic model_step(input logic [W-1:0] x);
    longint acc, gt[4], cn;
    for (int u = 0; u < 4; u++) begin
      for (int gg = 0; gg < 4; gg++) begin
        acc = longint'($signed(b4[u][gg])) * 4096 + longint'($signed(wx4[u][gg])) * longint'($signed(x));
        for (int k = 0; k < 4; k++) acc += longint'($signed(wh4[u][gg][k])) * mh[k];
        acc = sat16(acc >>> 12);
        gt[gg] = (gg == 2) ? clampl(acc, -4096, 4096) : clampl((acc >>> 2) + 2048, 0, 4096);
      end
      cn = sat16((gt[1] * mc[u] + gt[0] * gt[2]) >>> 12);
      ec[u] = cn;
      eh[u] = sat16((gt[3] * clampl(cn, -4096, 4096)) >>> 12);
    end
    for (int u = 0; u < 4; u++) begin
      mh[u] = eh[u];
      mc[u] = ec[u];
    end
  endtask

  task automatic model_vec(output logic [3:0][W-1:0] h, output logic [3:0][W-1:0] c);
    longint t;
    for (int u = 0; u < 4; u++) begin
      t = mh[u]; h[u] = t[W-1:0];
      t = mc[u]; c[u] = t[W-1:0];
    end
  endtask

  task automatic start1(input logic [W-1:0] x, input logic last);
    int n;
    @(negedge clk); x1 = x; xl1 = last; xv1 = 1'b1;
    n = 0;
    while (!xr1 && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk); xv1 = 1'b0;
  endtask

  task automatic wait1(output int lat);
    int n;
    n = 0;
    while (!yv1 && n < 500) begin @(negedge clk); n++; end
    lat = n;
  endtask

  task automatic ack1();
    yr1 = 1'b1; @(posedge clk); @(negedge clk); yr1 = 1'b0;
  endtask

  task automatic step4(input logic [W-1:0] x, input logic last,
                       output logic [3:0][W-1:0] h, output logic [3:0][W-1:0] c, output int lat);
    int n;
    @(negedge clk); x4 = x; xl4 = last; xv4 = 1'b1;
    n = 0;
    while (!xr4 && n < 500) begin @(negedge clk); n++; end
    @(posedge clk); @(negedge clk); xv4 = 1'b0;
    n = 0;
    while (!yv4 && n < 500) begin @(negedge clk); n++; end
    lat = n; h = y4; c = c4o;
    yr4 = 1'b1; @(posedge clk); @(negedge clk); yr4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    xv1 = 0; xl1 = 0; yr1 = 0; x1 = '0; wx1 = '0; wh1 = '0; b1 = '0; hi1 = '0; ci1 = '0;
    xv4 = 0; xl4 = 0; yr4 = 0; x4 = '0; wx4 = '0; wh4 = '0; b4 = '0; hi4 = '0; ci4 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (xr1 !== 1'b0 || xr4 !== 1'b0) begin
      failures++; $display("FAIL reset_x_ready got %b/%b want 0/0", xr1, xr4);
    end
    checks++;
    if (yv1 !== 1'b0 || yv4 !== 1'b0 || y4 !== '0 || c4o !== '0 || y1 !== '0 || c1o !== '0) begin
      failures++; $display("FAIL reset_outputs got yv=%b/%b y4=%h c4=%h want zeros", yv1, yv4, y4, c4o);
    end
    rst = 1'b1; #1;
    checks++;
    if (xr1 !== 1'b1 || xr4 !== 1'b1) begin
      failures++; $display("FAIL release_x_ready got %b/%b want 1/1", xr1, xr4);
    end
  endtask

  task automatic test_basic_unit1();
    int lat;
    ci1[0] = 16'd4096;
    start1(16'd0, 1'b1);
    checks++;
    if (xr1 !== 1'b0) begin failures++; $display("FAIL busy_x_ready got %b want 0", xr1); end
    wait1(lat);
    checks++;
    if (lat != 12) begin failures++; $display("FAIL latency_u1 got %0d want 12", lat); end
    checks++;
    if (y1[0] !== 16'd1024 || c1o[0] !== 16'd2048) begin
      failures++; $display("FAIL basic_u1 got y=%0d c=%0d want y=1024 c=2048", y1[0], c1o[0]);
    end
    ack1();
  endtask

  task automatic test_saturation();
    int lat;
    wx1[0][0] = 16'h7fff;
    b1[0][0] = 16'h7fff; b1[0][1] = 16'h8000; b1[0][2] = 16'h7fff; b1[0][3] = 16'h7fff;
    start1(16'h7fff, 1'b1);
    wait1(lat);
    checks++;
    if (y1[0] !== 16'd4096 || c1o[0] !== 16'd4096) begin
      failures++; $display("FAIL saturation got y=%0d c=%0d want 4096 4096", $signed(y1[0]), $signed(c1o[0]));
    end
    ack1();
  endtask

  task automatic test_back_pressure();
    int lat, bad;
    logic [W-1:0] hv, cv;
    start1(16'd1000, 1'b1);
    wait1(lat);
    hv = y1[0]; cv = c1o[0]; bad = 0;
    checks++;
    if (hv !== 16'd4096 || cv !== 16'd4096) begin
      failures++; $display("FAIL bp_value got y=%0d c=%0d want 4096 4096", hv, cv);
    end
    repeat (20) begin
      @(negedge clk);
      if (y1[0] !== hv || c1o[0] !== cv || xr1 !== 1'b0 || yv1 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
    ack1();
    checks++;
    if (xr1 !== 1'b1 || yv1 !== 1'b0) begin
      failures++; $display("FAIL bp_release got x_ready=%b y_valid=%b want 1 0", xr1, yv1);
    end
  endtask

  task automatic set_directed4();
    for (int u = 0; u < 4; u++) begin
      hi4[u] = W'(1000 * u - 1500);
      ci4[u] = W'(2000 - 700 * u);
      for (int g = 0; g < 4; g++) begin
        wx4[u][g] = W'((u * 4 + g) * 300 - 2000);
        b4[u][g]  = W'(500 * g - 800 + 100 * u);
        for (int k = 0; k < 4; k++) wh4[u][g][k] = W'(((u + 2 * g + 3 * k) % 7) * 600 - 1800);
      end
    end
  endtask

  task automatic test_sequence();
    logic [3:0][W-1:0] h1, c1, h2, c2, h3, c3, eh_v, ec_v;
    int lat;
    set_directed4();
    model_init();
    step4(16'd2500, 1'b0, h1, c1, lat);
    model_step(16'd2500); model_vec(eh_v, ec_v);
    checks++;
    if (lat != 93) begin failures++; $display("FAIL latency_u4 got %0d want 93", lat); end
    checks++;
    if (h1 !== eh_v || c1 !== ec_v) begin
      failures++; $display("FAIL seq_step1 got h=%h c=%h want h=%h c=%h", h1, c1, eh_v, ec_v);
    end
    step4(16'hf000, 1'b1, h2, c2, lat);
    model_step(16'hf000); model_vec(eh_v, ec_v);
    checks++;
    if (h2 !== eh_v || c2 !== ec_v) begin
      failures++; $display("FAIL seq_step2 got h=%h c=%h want h=%h c=%h", h2, c2, eh_v, ec_v);
    end
    step4(16'd2500, 1'b1, h3, c3, lat);
    checks++;
    if (h3 !== h1 || c3 !== c1) begin
      failures++; $display("FAIL seq_reload got h=%h c=%h want h=%h c=%h", h3, c3, h1, c1);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][W-1:0] h, c, eh_v, ec_v;
    int lat;
    @(negedge clk); x4 = 16'd777; xl4 = 1'b0; xv4 = 1'b1;
    @(posedge clk); @(negedge clk); xv4 = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (yv4 !== 1'b0 || xr4 !== 1'b0) begin
      failures++; $display("FAIL mid_reset_hold got y_valid=%b x_ready=%b want 0 0", yv4, xr4);
    end
    rst = 1'b1; #1;
    checks++;
    if (xr4 !== 1'b1 || yv4 !== 1'b0) begin
      failures++; $display("FAIL mid_reset_release got x_ready=%b y_valid=%b want 1 0", xr4, yv4);
    end
    model_init();
    step4(16'd2500, 1'b1, h, c, lat);
    model_step(16'd2500); model_vec(eh_v, ec_v);
    checks++;
    if (h !== eh_v || c !== ec_v || lat != 93) begin
      failures++; $display("FAIL mid_reset_next got h=%h c=%h lat=%0d want h=%h c=%h lat=93", h, c, lat, eh_v, ec_v);
    end
  endtask

  task automatic test_random_seq();
    logic [3:0][W-1:0] h, c, eh_v, ec_v;
    logic [W-1:0] x;
    int lat;
    for (int u = 0; u < 4; u++) begin
      hi4[u] = W'($urandom_range(0, 8191)) - 16'd4096;
      ci4[u] = W'($urandom_range(0, 8191)) - 16'd4096;
      for (int g = 0; g < 4; g++) begin
        wx4[u][g] = W'($urandom_range(0, 8191)) - 16'd4096;
        b4[u][g]  = W'($urandom_range(0, 4095)) - 16'd2048;
        for (int k = 0; k < 4; k++) wh4[u][g][k] = W'($urandom_range(0, 8191)) - 16'd4096;
      end
    end
    model_init();
    for (int i = 0; i < 50; i++) begin
      x = W'($urandom_range(0, 8191)) - 16'd4096;
      step4(x, i == 49, h, c, lat);
      model_step(x); model_vec(eh_v, ec_v);
      checks++;
      if (h !== eh_v || c !== ec_v || lat != 93) begin
        failures++;
        $display("FAIL random_step%0d got h=%h c=%h lat=%0d want h=%h c=%h lat=93", i, h, c, lat, eh_v, ec_v);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_unit1();
    test_saturation();
    test_back_pressure();
    test_sequence();
    test_reset_mid();
    test_random_seq();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
